lot_occupancy_ctrl: RTL

//   Occupancy controller for the parking lot. Consumes the one-cycle inc/dec

---
 rtl/lot_occupancy_ctrl.sv | 101 ++++++++++
 1 files changed

// File: rtl/lot_occupancy_ctrl.sv
// Parking lot occupancy counter with full/empty decode,
// sticky error flags and an entry gate sequencer.
module lot_occupancy_ctrl #(
  parameter int CAPACITY  = 15,
  parameter int CNT_W     = $clog2(CAPACITY + 1),
  parameter int GATE_HOLD = 50
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             dec,
  input  logic             req_entry,
  output logic [CNT_W-1:0] occupancy,
  output logic             full,
  output logic             empty,
  output logic             gate_open,
  output logic             err_overflow,
  output logic             err_underflow
);

  localparam int TMR_W = $clog2(GATE_HOLD);

  typedef enum logic [1:0] {
    CLOSED,
    OPEN,
    REARM
  } gate_e;

  gate_e            state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             full_w, empty_w;

  assign full_w  = (occ_q == CNT_W'(CAPACITY));
  assign empty_w = (occ_q == '0);

  // Simultaneous inc and dec cancel and never flag an error.
  always_comb begin
    occ_d = occ_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    if (inc && !dec) begin
      if (full_w) ovf_d = 1'b1;
      else        occ_d = occ_q + CNT_W'(1);
    end else if (dec && !inc) begin
      if (empty_w) unf_d = 1'b1;
      else         occ_d = occ_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    unique case (state_q)
      CLOSED: begin
        if (req_entry && !full_w) begin
          state_d = OPEN;
          timer_d = TMR_W'(GATE_HOLD - 1);
        end
      end
      OPEN: begin
        if (inc || (timer_q == '0)) begin
          state_d = REARM;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      REARM: begin
        // A held button must be released before the gate can reopen.
        if (!req_entry) state_d = CLOSED;
      end
      default: state_d = CLOSED;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLOSED;
      timer_q <= '0;
      occ_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      occ_q   <= occ_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign occupancy     = occ_q;
  assign full          = full_w;
  assign empty         = empty_w;
  assign gate_open     = (state_q == OPEN);
  assign err_overflow  = ovf_q;
  assign err_underflow = unf_q;

endmodule
